// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared types and default widths for the shared multiplier arbiter
package mul_arb_pkg;

    localparam int NREQ          = 2;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_IMM_WIDTH = 24;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_mul_core.sv
// rtl/shift_add_mul_core.sv - iterative shift-add multiplier, one multiplier bit per cycle
module shift_add_mul_core
    import mul_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int IMM_WIDTH = DEF_IMM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [IMM_WIDTH-1:0] b,
    output logic                 done,
    output logic [WIDTH-1:0]     result
);

    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     acc;
    logic [IMM_WIDTH-1:0] mul_b;
    logic [WIDTH-1:0]     partial;

    assign partial = mul_a & {WIDTH{mul_b[0]}};
    // Last step once the remaining multiplier is 0 or 1; result folds in that final partial.
    assign done    = (mul_b[IMM_WIDTH-1:1] == '0);
    assign result  = acc + partial;

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
        end else if (start) begin
            mul_a <= a;
            mul_b <= b;
            acc   <= '0;
        end else if (!done) begin
            acc   <= result;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one shift-add multiplier between two requesters
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int IMM_WIDTH = DEF_IMM_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*IMM_WIDTH-1:0] req_b,
    output logic                      rsp_valid,
    output logic                      rsp_id,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      busy
);

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             owner;
    logic             grant;
    logic             accept;
    logic             core_done;
    logic [WIDTH-1:0] core_result;

    shift_add_mul_core #(
        .WIDTH     (WIDTH),
        .IMM_WIDTH (IMM_WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (accept),
        .a      (grant ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH]),
        .b      (grant ? req_b[IMM_WIDTH +: IMM_WIDTH] : req_b[0 +: IMM_WIDTH]),
        .done   (core_done),
        .result (core_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = MUL;
            MUL:     if (core_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Tie goes to whoever did not win last; reset keeps accept off so rst beats a request.
    always_comb begin
        grant     = (&req_valid) ? ~last_grant : req_valid[1];
        req_ready = '0;
        accept    = 1'b0;
        busy      = (state == MUL);
        if (state == IDLE && !rst && |req_valid) begin
            accept           = 1'b1;
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                owner      <= grant;
                last_grant <= grant;
            end
            if (state == MUL && core_done) begin
                rsp_valid <= 1'b1;
                rsp_id    <= owner;
                rsp_data  <= core_result;
            end
        end
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one iterative shift-add multiplier between two requesters, such as two pipeline lanes or an execute stage plus a debug/config port.
- Arbitrates round-robin, captures operands, and sequences the multiply one bit per cycle.
- Data-dependent latency; returns a single-cycle tagged response.

Parameters:
- WIDTH, 32, multiplicand/result width
- IMM_WIDTH, 24, multiplier (immediate) width

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  2  per-requester request; bit i = requester i
- req_ready  output  2  one-hot accept; high for exactly the accepted requester in the accept cycle
- req_a  input  2*WIDTH  packed multiplicands; requester i at [i*WIDTH +: WIDTH]
- req_b  input  2*IMM_WIDTH  packed multipliers; requester i at [i*IMM_WIDTH +: IMM_WIDTH]
- rsp_valid  output  1  one-cycle result pulse
- rsp_id  output  1  requester index of rsp_data
- rsp_data  output  WIDTH  product modulo 2^WIDTH
- busy  output  1  high while state == MUL

Behaviour:
- Reset values:
  - state = IDLE
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0
  - internal mul_a = 0, mul_b = 0, acc = 0, owner = 0
  - last_grant = 1, so requester 0 wins the first tie.
- States:
  - IDLE: no multiply in progress.
  - MUL: multiply in progress.
  - No other states.
- IDLE:
  - req_ready is combinational from req_valid, state and last_grant.
  - Grant g:
    - Only one req_valid high: g is that requester.
    - Both high: g = ~last_grant.
  - On the accept edge:
    - mul_a <= req_a[g]; mul_b <= req_b[g]; acc <= 0
    - owner <= g; last_grant <= g; state <= MUL
  - No req_valid: remain in IDLE, req_ready = 0.
- MUL: req_ready = 00, busy = 1. Each cycle:
  - If mul_b == 0 or mul_b == 1:
    - rsp_data <= acc + (mul_a & {WIDTH{mul_b[0]}})
    - rsp_id <= owner; rsp_valid <= 1; state <= IDLE
  - Else:
    - acc <= acc + (mul_a & {WIDTH{mul_b[0]}})
    - mul_a <= mul_a << 1; mul_b <= mul_b >> 1
- Latency:
  - Accept edge at end of cycle T; MUL occupies cycles T+1 .. T+n.
  - n = 1 if b <= 1, else bit-length of b.
  - rsp_valid is high in cycle T+n+1.
- rsp_valid is a single-cycle pulse; rsp_id and rsp_data hold their values until the next response.
- Back-to-back:
  - The cycle with rsp_valid = 1 is an IDLE cycle, so a new request may be accepted in it.
  - Minimum spacing between accepts is n+1 cycles.
- Arithmetic:
  - All sums truncate to WIDTH bits; overflow is silently discarded.
  - mul_a is WIDTH bits; its shifted-out MSBs are lost.
- Requester protocol:
  - A requester holds req_valid and its operands stable until it sees its req_ready bit.
  - A requester deasserting before accept is legal: no side effect.
  - The block never drops an accepted request.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Reset mid-MUL: operation aborted, no response issued, all state returns to reset values on the next edge.
- Simultaneous rst and req_valid: rst wins, no accept.

Decomposition:
- Package mul_arb_pkg holds:
  - state enum {IDLE, MUL}
  - NREQ = 2
  - localparams for default widths
- One sub-module, shift_add_mul_core:
  - holds mul_a/mul_b/acc and the one-bit-per-cycle step.
  - Interface: start, a, b → done, result.
- mul_arbiter holds the arbitration, owner tag and response registers.

Test Plan:
- Reset, then req0 with a=3, b=5 → req_ready=01 at T; busy for 3 cycles; rsp_valid at T+4 with rsp_id=0, rsp_data=15.
- req1 with a=7, b=1, then a=7, b=0 → each completes in 1 MUL cycle; responses rsp_data=7 then rsp_data=0, rsp_id=1.
- After reset, both requesters valid with a0=2, b0=3 and a1=4, b1=6:
  - first grant is req0, response 6 (id 0);
  - req1 is accepted in the response cycle, response 24 (id 1);
  - further contention alternates 0,1,0,1.
- Overflow: a=0x80000000, b=2 → rsp_data=0 after 2 MUL cycles; a=0xFFFFFFFF, b=3 → rsp_data=0xFFFFFFFD.
- Assert rst in the second MUL cycle of a b=0xFFFFFF operation → no rsp_valid; busy=0 next cycle; the next request behaves as after a fresh reset (req0 wins a tie).
- req_valid pulses low for one cycle while busy → req_ready stays 00 throughout MUL; the request is accepted only once it is valid in IDLE.
